// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/valid memory handshake and
// presents them to control_unit under valid/ready, handling redirects, stale responses and faults.
module instruction_fetch #(
  parameter int                  WORDSIZE         = 64,
  parameter int                  INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] PC_RESET         = {WORDSIZE{1'b0}}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        if_imem_req,
  output logic [WORDSIZE-1:0]         if_imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] if_imem_rdata,
  input  logic                        if_imem_valid,
  output logic [INSTRUCTION_SIZE-1:0] if_instruction,
  output logic                        if_instr_valid,
  input  logic                        if_cu_ready,
  output logic [WORDSIZE-1:0]         if_pc,
  input  logic                        if_redirect_en,
  input  logic [WORDSIZE-1:0]         if_redirect_pc,
  output logic                        if_fault,
  output logic [WORDSIZE-1:0]         if_retired
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [INSTRUCTION_SIZE-1:0] NOP = INSTRUCTION_SIZE'(32'h0000_0013);

  state_t                      state_q;
  logic [WORDSIZE-1:0]         pc_q;
  logic [WORDSIZE-1:0]         retired_q;
  logic [INSTRUCTION_SIZE-1:0] word_q;
  logic                        req_q;
  logic                        valid_q;
  logic                        fault_q;
  logic                        misaligned_s;

  function automatic logic is_misaligned(input logic [WORDSIZE-1:0] target);
    return (target[1:0] != 2'b00);
  endfunction

  assign misaligned_s = if_redirect_en & is_misaligned(if_redirect_pc);

  // Fetch FSM; req/valid/fault are produced as registers alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= PC_RESET;
      retired_q <= {WORDSIZE{1'b0}};
      word_q    <= NOP;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else if (misaligned_s && state_q != HALT) begin
      // A misaligned target freezes the PC and parks the stage until reset.
      state_q <= HALT;
      fault_q <= 1'b1;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (if_redirect_en) begin
            pc_q <= if_redirect_pc;
          end else begin
            pc_q <= pc_q;
          end
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (if_redirect_en) begin
            pc_q <= if_redirect_pc;
            if (if_imem_valid) begin
              state_q <= FETCH;
              req_q   <= 1'b1;
            end else begin
              state_q <= DRAIN;
              req_q   <= 1'b0;
            end
          end else if (if_imem_valid) begin
            word_q  <= if_imem_rdata;
            state_q <= ISSUE;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            state_q <= FETCH;
          end
        end
        ISSUE: begin
          if (if_redirect_en) begin
            pc_q    <= if_redirect_pc;
            state_q <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end else if (if_cu_ready) begin
            pc_q      <= pc_q + WORDSIZE'(4);
            retired_q <= retired_q + WORDSIZE'(1);
            state_q   <= FETCH;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
          end else begin
            state_q <= ISSUE;
          end
        end
        DRAIN: begin
          if (if_redirect_en) begin
            pc_q <= if_redirect_pc;
          end else begin
            pc_q <= pc_q;
          end
          // The one outstanding response belongs to the abandoned PC and is thrown away.
          if (if_imem_valid) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end else begin
            state_q <= DRAIN;
          end
        end
        HALT: begin
          state_q <= HALT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= HALT;
          fault_q <= 1'b1;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_imem_req    = req_q;
  assign if_imem_addr   = pc_q;
  assign if_pc          = pc_q;
  assign if_instr_valid = valid_q;
  assign if_fault       = fault_q;
  assign if_retired     = retired_q;
  assign if_instruction = valid_q ? word_q : NOP;

endmodule
